// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - N-bit modulo-M up/down counter with load, wrap/saturate, tc pulse and sticky ovf
// Define UPDOWN_COUNTER_GRAY_OUT_EN to present count as the Gray code of the internal binary value.
module updown_counter_n #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned       MAX_I   = MODULO - 1;
  localparam logic [WIDTH-1:0]  MAX_VAL = MAX_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0]  ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q;
  logic             tc_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      // Clamp compares against MODULO-1 so the bound never needs WIDTH+1 bits.
      bin_q <= (din > MAX_VAL) ? MAX_VAL : din;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (E) begin
      if (bin_q > MAX_VAL) begin
        bin_q <= '0;
        tc_q  <= 1'b0;
      end else if (x) begin
        if (bin_q == MAX_VAL) begin
          bin_q <= sat_mode ? MAX_VAL : '0;
          tc_q  <= 1'b1;
          ovf_q <= 1'b1;
        end else begin
          bin_q <= bin_q + ONE;
          tc_q  <= 1'b0;
        end
      end else begin
        if (bin_q == '0) begin
          bin_q <= sat_mode ? '0 : MAX_VAL;
          tc_q  <= 1'b1;
          ovf_q <= 1'b1;
        end else begin
          bin_q <= bin_q - ONE;
          tc_q  <= 1'b0;
        end
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
  // Pure function of the register, so latency matches the binary output.
  assign count = bin_q ^ (bin_q >> 1);
`else
  assign count = bin_q;
`endif

  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - directed self-checking bench for updown_counter_n (WIDTH=4, MODULO=10)
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       E = 1'b0;
  logic       x = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic       sat_mode = 1'b0;
  logic [3:0] count;
  logic       tc;
  logic       ovf;

  int checks = 0;
  int failures = 0;

  updown_counter_n #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .reset(reset), .E(E), .x(x), .load(load), .din(din),
    .sat_mode(sat_mode), .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then check all outputs 1 time unit later.
  task automatic step(input string tag, input logic rst, input logic e, input logic xx,
                      input logic ld, input logic [3:0] d, input logic sm,
                      input logic [3:0] exp_count, input logic exp_tc, input logic exp_ovf);
    reset = rst; E = e; x = xx; load = ld; din = d; sat_mode = sm;
    @(posedge clk);
    #1;
    chk({tag, ".count"}, count, exp_count);
    chk({tag, ".tc"}, {3'b0, tc}, {3'b0, exp_tc});
    chk({tag, ".ovf"}, {3'b0, ovf}, {3'b0, exp_ovf});
  endtask

  initial begin
    logic [3:0] up_seq [12];
    up_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

    step("reset0", 1, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0);
    step("reset1", 1, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold0", 0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0);

    for (int i = 0; i < 12; i++)
      step($sformatf("up_wrap%0d", i), 0, 1, 1, 0, 4'd0, 0, up_seq[i], (i == 9), (i >= 9));

    step("hold_sticky", 0, 0, 1, 0, 4'd0, 0, 4'd2, 0, 1);

    step("load2", 0, 0, 0, 1, 4'd2, 1, 4'd2, 0, 0);
    step("dn_sat0", 0, 1, 0, 0, 4'd0, 1, 4'd1, 0, 0);
    step("dn_sat1", 0, 1, 0, 0, 4'd0, 1, 4'd0, 0, 0);
    step("dn_sat2", 0, 1, 0, 0, 4'd0, 1, 4'd0, 1, 1);
    step("dn_sat3", 0, 1, 0, 0, 4'd0, 1, 4'd0, 1, 1);

    step("load_clamp", 0, 0, 0, 1, 4'd13, 0, 4'd9, 0, 0);
    step("dn_after_clamp", 0, 1, 0, 0, 4'd0, 0, 4'd8, 0, 0);

    step("load_wins", 0, 1, 1, 1, 4'd5, 0, 4'd5, 0, 0);
    step("reset_wins", 1, 1, 1, 1, 4'd7, 0, 4'd0, 0, 0);

    step("dn_wrap", 0, 1, 0, 0, 4'd0, 0, 4'd9, 1, 1);
    step("up_sat", 0, 1, 1, 0, 4'd0, 1, 4'd9, 1, 1);
    step("load_max", 0, 1, 1, 1, 4'd9, 1, 4'd9, 0, 0);
    step("up_wrap_top", 0, 1, 1, 0, 4'd0, 0, 4'd0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
- Parametrised successor of the team's 2-bit enable/direction sequential counter.
- N-bit modulo-M up/down counter with:
  - enable E and direction x (same meaning as before)
  - synchronous parallel load
  - selectable wrap or saturate mode
  - registered terminal-count pulse and sticky overflow flag
- Used as a general step/sequence counter in the lab designs.

Parameters:
- WIDTH, 4: counter width in bits (>=2).
- MODULO, 16: count range 0..MODULO-1; must satisfy 2 <= MODULO <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- E  input  1  count enable; 0 = hold.
- x  input  1  direction; 1 = up, 0 = down.
- load  input  1  synchronous parallel load request.
- din  input  WIDTH  load value.
- sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
- count  output  WIDTH  current count (binary; Gray if feature enabled).
- tc  output  1  one-cycle terminal-count/boundary pulse.
- ovf  output  1  sticky boundary-event flag.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- All state updates on posedge clk. Priority per edge: reset > load > count (E=1) > hold.
- Reset: count=0, tc=0, ovf=0. Reset mid-count overrides load and E on that edge.
- Load (load=1):
  - count <= din if din < MODULO, else count <= MODULO-1 (clamp).
  - tc <= 0; ovf <= 0. E and x are ignored that cycle.
- Hold (E=0, load=0): count unchanged; tc <= 0; ovf unchanged.
- Up step (E=1, x=1):
  - count < MODULO-1: count+1.
  - count == MODULO-1: boundary event. sat_mode=0 gives count <= 0; sat_mode=1 holds MODULO-1.
- Down step (E=1, x=0):
  - count > 0: count-1.
  - count == 0: boundary event. sat_mode=0 gives count <= MODULO-1; sat_mode=1 holds 0.
- Boundary event on an edge:
  - tc = 1 for exactly the following cycle.
  - ovf = 1 and stays set until reset or load.
  - In saturate mode, every further blocked step re-asserts tc, so tc is high continuously while pushing against the boundary.
- tc = 0 on every edge without a boundary event.
- Latency: count, tc and ovf are all registered; each reflects the inputs sampled at the previous rising edge. No combinational path from inputs to outputs.
- Arithmetic:
  - Internal compare and increment use WIDTH bits. No intermediate value may exceed MODULO-1.
  - When MODULO = 2**WIDTH, the wrap matches natural binary overflow.
- Changing x or sat_mode between edges is legal. Only the values sampled at the edge matter.
- Out-of-range states cannot occur. Defensively, if count >= MODULO it is forced to 0 on the next enabled edge.

Optional Feature:
- Macro: UPDOWN_COUNTER_GRAY_OUT_EN.
- Defined:
  - count presents the Gray code of the internal binary value (bin ^ (bin >> 1)), registered with the same latency.
  - Internal counting, load (din is binary), tc and ovf are unchanged.
  - Gray adjacency at the wrap is guaranteed only when MODULO is a power of two.
- Not defined: count is the plain binary value. No extra logic or registers.

Test Plan (WIDTH=4, MODULO=10 unless stated):
- reset=1 for 2 edges with E=1, x=1 -> count=0, tc=0, ovf=0. Then hold E=0 for 3 edges -> count stays 0.
- E=1, x=1, sat_mode=0 from 0 for 12 edges -> count goes 1..9, 0, 1, 2. tc high only in the cycle after 9->0. ovf=1 from then on.
- load=1, din=2, then E=1, x=0, sat_mode=1 for 4 edges -> count 2, 1, 0, 0, 0. tc high after each blocked step at 0. ovf=1.
- load=1, din=13 -> count=9 (clamped), tc=0, ovf cleared to 0. Next edge E=1, x=0 -> 8.
- Simultaneous load=1, din=5, E=1, x=1 -> count=5 (load wins). Then reset=1 with load=1 on the same edge -> count=0.
- With UPDOWN_COUNTER_GRAY_OUT_EN, MODULO=16, counting up 0..15..0 -> count sequence 0000, 0001, 0011, 0010, …, 1000, 0000. Consecutive values differ in exactly one bit, including the wrap.
